// File: rtl/floor_request_panel.sv
// -----------------------------------------------------------------------------
// floor_request_panel
//
// Turns a raw, bouncy, active-low request pushbutton plus a binary floor code
// into a clean pending-request bitmap for the elevator state controller. The
// controller clears floors with one-hot "served" masks. Dispatch helpers
// (pending count, lowest/highest pending floor) are derived combinationally
// from the bitmap.
//
// Ports:
//   CLOCK_50         in   system clock
//   rst              in   asynchronous active-high reset
//   key_n            in   raw active-low pushbutton, asynchronous to CLOCK_50
//   floor_code       in   requested floor, binary, 1-based
//   serve_valid      in   one-cycle strobe qualifying serve_floor
//   serve_floor      in   mask of served floors (bit i = floor i+1)
//   floor_reg        out  pending request bitmap (bit i = floor i+1)
//   req_pulse        out  one-cycle pulse, a new floor bit was set
//   reject_pulse     out  one-cycle pulse, accepted press had an illegal code
//   pending_count    out  population count of floor_reg (combinational)
//   lowest_pending   out  one-hot lowest set bit of floor_reg (combinational)
//   highest_pending  out  one-hot highest set bit of floor_reg (combinational)
// -----------------------------------------------------------------------------
module floor_request_panel #(
    parameter int unsigned NUM_FLOORS      = 10,
    parameter int unsigned CODE_W          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic                  CLOCK_50,
    input  logic                  rst,
    input  logic                  key_n,
    input  logic [CODE_W-1:0]     floor_code,
    input  logic                  serve_valid,
    input  logic [NUM_FLOORS-1:0] serve_floor,
    output logic [NUM_FLOORS-1:0] floor_reg,
    output logic                  req_pulse,
    output logic                  reject_pulse,
    output logic [3:0]            pending_count,
    output logic [NUM_FLOORS-1:0] lowest_pending,
    output logic [NUM_FLOORS-1:0] highest_pending
);

    localparam int unsigned PCNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_RELEASED     = 2'd0,
        S_PRESS_WAIT   = 2'd1,
        S_PRESSED      = 2'd2,
        S_RELEASE_WAIT = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // Two-flop synchronizer; resets to the released (high) level
    // -------------------------------------------------------------------------
    logic r_sync1;
    logic r_sync2;
    logic w_key_s;

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
        end
    end

    assign w_key_s = r_sync2;

    // -------------------------------------------------------------------------
    // Debounce FSM: state/counter registers
    // -------------------------------------------------------------------------
    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next_cnt;
    logic             w_accept;
    logic             r_accept;

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            r_state  <= S_RELEASED;
            r_cnt    <= CNT_ZERO;
            r_accept <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_cnt    <= w_next_cnt;
            r_accept <= w_accept;
        end
    end

    // Debounce FSM: next state, counter and one-shot accept on debounced press
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_accept     = 1'b0;
        unique case (r_state)
            S_RELEASED: begin
                if (!w_key_s) begin
                    w_next_state = S_PRESS_WAIT;
                    w_next_cnt   = CNT_ONE;
                end
            end
            S_PRESS_WAIT: begin
                if (w_key_s) begin
                    w_next_state = S_RELEASED;
                    w_next_cnt   = CNT_ZERO;
                end else if (r_cnt == CNT_LAST) begin
                    w_next_state = S_PRESSED;
                    w_next_cnt   = CNT_ZERO;
                    w_accept     = 1'b1;
                end else begin
                    w_next_cnt = r_cnt + CNT_ONE;
                end
            end
            S_PRESSED: begin
                if (w_key_s) begin
                    w_next_state = S_RELEASE_WAIT;
                    w_next_cnt   = CNT_ONE;
                end
            end
            S_RELEASE_WAIT: begin
                if (!w_key_s) begin
                    w_next_state = S_PRESSED;
                    w_next_cnt   = CNT_ZERO;
                end else if (r_cnt == CNT_LAST) begin
                    w_next_state = S_RELEASED;
                    w_next_cnt   = CNT_ZERO;
                end else begin
                    w_next_cnt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_next_state = S_RELEASED;
                w_next_cnt   = CNT_ZERO;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Request bitmap update: serve clear is applied before the accept set, so
    // a floor served and re-requested in the same cycle ends up pending again
    // and is reported as a fresh request.
    // -------------------------------------------------------------------------
    logic [NUM_FLOORS-1:0] r_floor_reg;
    logic                  r_req_pulse;
    logic                  r_reject_pulse;
    logic [NUM_FLOORS-1:0] w_set_mask;
    logic [NUM_FLOORS-1:0] w_cleared;
    logic [NUM_FLOORS-1:0] w_next_floor;
    logic                  w_legal;
    logic                  w_req;
    logic                  w_reject;

    // Decode floor code to one-hot; illegal codes (0, >NUM_FLOORS) decode to 0
    always_comb begin
        w_set_mask = '0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            w_set_mask[i] = (floor_code == CODE_W'(i + 1));
        end
    end

    assign w_legal   = |w_set_mask;
    assign w_cleared = serve_valid ? (r_floor_reg & ~serve_floor) : r_floor_reg;

    always_comb begin
        w_next_floor = w_cleared;
        w_req        = 1'b0;
        w_reject     = 1'b0;
        if (r_accept) begin
            if (w_legal) begin
                w_next_floor = w_cleared | w_set_mask;
                w_req        = ((w_cleared & w_set_mask) == '0);
            end else begin
                w_reject = 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            r_floor_reg    <= '0;
            r_req_pulse    <= 1'b0;
            r_reject_pulse <= 1'b0;
        end else begin
            r_floor_reg    <= w_next_floor;
            r_req_pulse    <= w_req;
            r_reject_pulse <= w_reject;
        end
    end

    assign floor_reg    = r_floor_reg;
    assign req_pulse    = r_req_pulse;
    assign reject_pulse = r_reject_pulse;

    // -------------------------------------------------------------------------
    // Dispatch helpers, zero latency from floor_reg
    // -------------------------------------------------------------------------
    logic [PCNT_W-1:0]     w_count;
    logic [NUM_FLOORS-1:0] w_lowest;
    logic [NUM_FLOORS-1:0] w_highest;
    logic                  w_lo_found;
    logic                  w_hi_found;

    always_comb begin
        w_count = '0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            w_count = w_count + PCNT_W'(r_floor_reg[i]);
        end
    end

    // Scan up for the first set bit and down for the last set bit
    always_comb begin
        w_lowest   = '0;
        w_highest  = '0;
        w_lo_found = 1'b0;
        w_hi_found = 1'b0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            if (r_floor_reg[i] && !w_lo_found) begin
                w_lowest[i] = 1'b1;
                w_lo_found  = 1'b1;
            end
            if (r_floor_reg[NUM_FLOORS-1-i] && !w_hi_found) begin
                w_highest[NUM_FLOORS-1-i] = 1'b1;
                w_hi_found                = 1'b1;
            end
        end
    end

    assign pending_count   = w_count;
    assign lowest_pending  = w_lowest;
    assign highest_pending = w_highest;

endmodule

// File: doc/floor_request_panel.md
Name: floor_request_panel

Overview:
- Producer side of the floor-request interface consumed by the elevator state controller.
- Turns raw pushbutton presses (KEY[0]) plus a 4-bit floor code (SW[3:0]) into a clean pending-request bitmap `floor_reg`.
- Accepts one-hot "floor served" acknowledgements from the controller and clears the matching bits.
- Also provides request/reject pulses, a pending count and lowest/highest pending floor for dispatch logic.

Parameters:
- NUM_FLOORS, 10, number of floors; bitmap width; legal codes 1..NUM_FLOORS.
- CODE_W, 4, width of floor code input.
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles (10 ms at 50 MHz) required to accept a press or a release.
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- CLOCK_50  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- key_n  in  1  raw active-low request pushbutton, asynchronous to CLOCK_50.
- floor_code  in  CODE_W  requested floor number, binary, 1-based.
- serve_valid  in  1  one-cycle pulse from controller: floors in serve_floor have been served.
- serve_floor  in  NUM_FLOORS  mask of served floors; bit i = floor i+1.
- floor_reg  out  NUM_FLOORS  pending request bitmap; bit i = floor i+1.
- req_pulse  out  1  one-cycle pulse: a new floor bit was set.
- reject_pulse  out  1  one-cycle pulse: accepted press carried an illegal code.
- pending_count  out  4  population count of floor_reg.
- lowest_pending  out  NUM_FLOORS  one-hot lowest set bit of floor_reg; 0 if none.
- highest_pending  out  NUM_FLOORS  one-hot highest set bit of floor_reg; 0 if none.

Behaviour:
- Reset (async, while rst=1):
  - floor_reg=0, req_pulse=0, reject_pulse=0.
  - Sync flops = 1 (released), debounce counter=0, FSM=RELEASED.
  - Combinational outputs follow floor_reg (all 0).
- Synchronizer: key_n passes through 2 flops before use, giving key_s. Nothing else samples key_n.
- Debounce FSM states: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - RELEASED: key_s=0 -> PRESS_WAIT, counter=1.
  - PRESS_WAIT: key_s=1 -> RELEASED, counter=0 (bounce). key_s=0 and counter==DEBOUNCE_CYCLES-1 -> PRESSED and raise one-cycle internal accept. Otherwise counter+1.
  - PRESSED: key_s=1 -> RELEASE_WAIT, counter=1.
  - RELEASE_WAIT: key_s=0 -> PRESSED, counter=0. key_s=1 and counter==DEBOUNCE_CYCLES-1 -> RELEASED. Otherwise counter+1.
  - Exactly one accept per debounced press, regardless of hold length.
- Accept handling:
  - floor_code is sampled in the accept cycle. Changes to floor_code while held are ignored.
  - code in 1..NUM_FLOORS and bit code-1 clear: set the bit at the next edge and assert req_pulse on that same edge.
  - Bit already set: no change, no pulse.
  - code 0 or code > NUM_FLOORS: floor_reg unchanged; reject_pulse for one cycle at the next edge.
- Latency: a clean press is visible on floor_reg/req_pulse DEBOUNCE_CYCLES+3 edges after key_n falls (2 sync + DEBOUNCE_CYCLES + 1 register).
- Serve handling:
  - When serve_valid=1, floor_reg <= floor_reg & ~serve_floor at the next edge.
  - Multiple bits may be cleared at once; serve_floor=0 is a no-op.
  - serve_floor is ignored when serve_valid=0.
- Simultaneous accept and serve in one cycle: the clear applies first, then the set.
  - Same floor: bit ends 1 and req_pulse is asserted (request re-registered).
  - Different floors: both take effect.
- Combinational outputs (zero latency from floor_reg):
  - pending_count ranges 0..NUM_FLOORS.
  - lowest_pending / highest_pending are equal when exactly one bit is set; both 0 when none are set.
- Reset mid-operation: an in-progress debounce is discarded, with no accept. A key still held after rst deasserts is treated as a fresh press and accepted after full debounce.
- req_pulse and reject_pulse are never both 1.

Test Plan (bench uses DEBOUNCE_CYCLES=4):
1. rst pulse, then code=3 and clean 20-cycle press -> floor_reg=10'b0000000100 on edge 7 after key_n falls; req_pulse high 1 cycle; pending_count=1; lowest=highest=10'b0000000100.
2. Bouncy press (key_n 0,1,0,1 each for 2 cycles, then steady 0), code=5 -> single accept, floor_reg bit4 set once, exactly one req_pulse; holding 100 cycles produces no further pulse.
3. Presses with code=0, then code=12 -> floor_reg unchanged; reject_pulse pulses twice; req_pulse never asserted.
4. Codes 2, 7, 10 pending, then serve_valid with serve_floor=10'b0001000000 -> floor_reg=10'b1000000010; pending_count=2; lowest=10'b0000000010; highest=10'b1000000000.
5. Floor 4 pending; accept for code 4 and serve_valid with serve_floor=10'b0000001000 in the same cycle -> bit3 remains 1; req_pulse asserted.
6. Assert rst 2 cycles into PRESS_WAIT with key held low and floor_reg=10'b0000010001 -> floor_reg=0 immediately (async); after rst falls, key still low with code=9 -> bit8 set after full debounce; one req_pulse.
